fpt_core_scheduler: RTL and testbench
=====================================

Name: fpt_core_scheduler

Overview:
Shares one psi_fpt_core instance between two requesters: port 0 carries the local PMOD sensor/motor stream, port 1 carries the nRF swarm relay.
- Round-robin arbitration, one transaction in flight.
- Issues a one-cycle valid strobe to the core, then samples the core's correction/veto a fixed latency later.
- Returns the result to the winning requester.
- After any veto, enforces a no-issue hold-off window.

Parameters:
CORE_LAT, 4, cycles from the core_valid cycle to the cycle core_correction/core_veto are sampled (legal 1..15)
VETO_HOLD, 1000, hold-off cycles after a vetoed transaction (legal 1..65535)
DW, 16, data width of scrape/motor/correction

Ports:
clk_100mhz  in  1  system clock
rst  in  1  asynchronous active-high reset
s0_valid  in  1  port 0 request
s0_ready  out  1  port 0 accept strobe
s0_scrape  in  DW  port 0 sensor scrape
s0_motor  in  DW  port 0 motor command
s1_valid  in  1  port 1 request
s1_ready  out  1  port 1 accept strobe
s1_scrape  in  DW  port 1 sensor scrape
s1_motor  in  DW  port 1 motor command
core_valid  out  1  one-cycle strobe to core sensor_valid
core_scrape  out  DW  registered scrape to core
core_motor  out  DW  registered motor command to core
core_correction  in  DW  core motor_correction
core_veto  in  1  core veto_out
resp_valid  out  1  result available
resp_ready  in  1  result consumer ready
resp_id  out  1  port that owns the result
resp_correction  out  DW  captured correction
resp_veto  out  1  captured veto
holdoff  out  1  hold-off window active
busy  out  1  state != IDLE
veto_count  out  8  saturating count of vetoed transactions

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All outputs are 0: core_valid, s0_ready/s1_ready, resp_*, holdoff, busy, veto_count, core_scrape, core_motor.
  - last_grant=1, so port 0 wins the first contention.
  - Asserting rst mid-transaction abandons it: no response and no veto_count change.
- States: IDLE, ISSUE, WAIT, RESP, HOLD.
- Handshake: sX_ready is a combinational one-cycle accept strobe, asserted only in IDLE, to the granted port. A request is accepted in the cycle sX_valid & sX_ready. Requesters hold valid and data stable until accepted.
- IDLE arbitration:
  - Both valid: grant the port != last_grant.
  - One valid: grant that port.
  - On grant: latch scrape/motor into core_scrape/core_motor, latch the port into resp_id, update last_grant, go to ISSUE.
- ISSUE (1 cycle): core_valid=1. Load lat_cnt=CORE_LAT-1, go to WAIT.
- WAIT: decrement lat_cnt each cycle. In the cycle lat_cnt==0, capture core_correction/core_veto into resp_correction/resp_veto and go to RESP. The capture cycle is exactly CORE_LAT cycles after the core_valid cycle.
- RESP:
  - resp_valid=1 held until resp_ready (resp_ready may already be high on entry; the transfer takes 1 cycle).
  - On transfer: if resp_veto=1, load hold_cnt=VETO_HOLD-1 and go to HOLD; else go to IDLE.
  - veto_count increments on the capture cycle when core_veto=1 and saturates at 255.
- HOLD: holdoff=1, no grants, sX_ready=0. Decrement hold_cnt; at hold_cnt==0 go to IDLE. Requests arriving during HOLD wait.
- Minimum transaction: IDLE→ISSUE→WAIT(CORE_LAT cycles)→RESP = CORE_LAT+2 cycles plus response stall.
- core_correction/core_veto are ignored outside the capture cycle.
- busy = (state != IDLE). holdoff is registered and equals (state==HOLD).
- Widths: counters are sized for the parameter maxima. No arithmetic on data.

Test Plan:
1. Reset: rst=1 for 3 cycles, release → all outputs 0, state IDLE, first contention goes to port 0.
2. Single request: s0_valid with scrape=0x1234, motor=0x00FF; core returns correction=0xBEEF, veto=0 at CORE_LAT=4 → core_valid pulses once with 0x1234/0x00FF, resp_valid rises 6 cycles after accept, resp_id=0, resp_correction=0xBEEF.
3. Contention: s0 and s1 held valid continuously, resp_ready=1 → grants alternate 0,1,0,1 with no port starved.
4. Veto hold-off: VETO_HOLD=8, core_veto=1 on the capture cycle → veto_count=1, holdoff=1 for exactly 8 cycles, no sX_ready during hold-off, next grant on the cycle after holdoff falls.
5. Response backpressure: resp_ready=0 for 10 cycles → resp_valid held with stable data, no new grant, a single transfer on release.
6. Saturation and reset: 260 vetoed transactions with VETO_HOLD=1 → veto_count stops at 255. Assert rst during WAIT → immediate return to IDLE, no resp_valid.

Source files
------------

// File: rtl/fpt_core_scheduler.sv
// Round-robin scheduler that time-shares one psi_fpt_core between the PMOD stream (port 0)
// and the nRF swarm relay (port 1), with a veto-triggered no-issue hold-off window.
module fpt_core_scheduler #(
   parameter int unsigned CORE_LAT  = 4,
   parameter int unsigned VETO_HOLD = 1000,
   parameter int unsigned DW        = 16
) (
   input  logic          clk_100mhz,
   input  logic          rst,
   input  logic          s0_valid,
   output logic          s0_ready,
   input  logic [DW-1:0] s0_scrape,
   input  logic [DW-1:0] s0_motor,
   input  logic          s1_valid,
   output logic          s1_ready,
   input  logic [DW-1:0] s1_scrape,
   input  logic [DW-1:0] s1_motor,
   output logic          core_valid,
   output logic [DW-1:0] core_scrape,
   output logic [DW-1:0] core_motor,
   input  logic [DW-1:0] core_correction,
   input  logic          core_veto,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic          resp_id,
   output logic [DW-1:0] resp_correction,
   output logic          resp_veto,
   output logic          holdoff,
   output logic          busy,
   output logic [7:0]    veto_count
);

   localparam int unsigned LW = 4;
   localparam int unsigned HW = 16;
   localparam logic [LW-1:0] LAT_LOAD  = LW'(CORE_LAT - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(VETO_HOLD - 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StHold} state_t;

   state_t        state_q, state_d;
   logic          last_grant_q;
   logic [LW-1:0] lat_cnt_q;
   logic [HW-1:0] hold_cnt_q;
   logic          grant_vld;
   logic          grant_port;

   // Under contention the port that did not win last time goes first.
   always_comb begin
      grant_vld = s0_valid | s1_valid;
      if (s0_valid && s1_valid) begin
         grant_port = ~last_grant_q;
      end else begin
         grant_port = s1_valid;
      end
   end

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      s0_ready   = 1'b0;
      s1_ready   = 1'b0;
      core_valid = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         StIdle: begin
            if (grant_vld) begin
               s0_ready = ~grant_port;
               s1_ready = grant_port;
               state_d  = StIssue;
            end
         end
         StIssue: begin
            core_valid = 1'b1;
            state_d    = StWait;
         end
         StWait: begin
            if (lat_cnt_q == '0) begin
               state_d = StResp;
            end
         end
         StResp: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = resp_veto ? StHold : StIdle;
            end
         end
         StHold: begin
            if (hold_cnt_q == '0) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy = (state_q != StIdle);

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         last_grant_q    <= 1'b1;
         core_scrape     <= '0;
         core_motor      <= '0;
         resp_id         <= 1'b0;
         resp_correction <= '0;
         resp_veto       <= 1'b0;
         lat_cnt_q       <= '0;
         hold_cnt_q      <= '0;
         holdoff         <= 1'b0;
         veto_count      <= '0;
      end else begin
         holdoff <= (state_d == StHold);
         case (state_q)
            StIdle: begin
               if (grant_vld) begin
                  core_scrape  <= grant_port ? s1_scrape : s0_scrape;
                  core_motor   <= grant_port ? s1_motor : s0_motor;
                  resp_id      <= grant_port;
                  last_grant_q <= grant_port;
               end
            end
            StIssue: lat_cnt_q <= LAT_LOAD;
            StWait: begin
               // Core outputs are only meaningful CORE_LAT cycles after the strobe.
               if (lat_cnt_q == '0) begin
                  resp_correction <= core_correction;
                  resp_veto       <= core_veto;
                  if (core_veto && (veto_count != 8'hFF)) begin
                     veto_count <= veto_count + 8'd1;
                  end
               end else begin
                  lat_cnt_q <= lat_cnt_q - LW'(1);
               end
            end
            StResp: begin
               if (resp_ready && resp_veto) begin
                  hold_cnt_q <= HOLD_LOAD;
               end
            end
            StHold: begin
               if (hold_cnt_q != '0) begin
                  hold_cnt_q <= hold_cnt_q - HW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpt_core_scheduler.sv
// Randomized scoreboard bench for fpt_core_scheduler: a timeline reference model predicts
// grants, strobes, response windows and hold-off; a monitor checks payloads as they appear.
module tb_fpt_core_scheduler;

   localparam int unsigned L  = 4;
   localparam int unsigned VH = 8;
   localparam int unsigned DW = 16;

   logic          clk_100mhz = 1'b0;
   logic          rst = 1'b1;
   logic          s0_valid = 1'b0, s1_valid = 1'b0;
   logic          s0_ready, s1_ready;
   logic [DW-1:0] s0_scrape = '0, s0_motor = '0, s1_scrape = '0, s1_motor = '0;
   logic          core_valid;
   logic [DW-1:0] core_scrape, core_motor;
   logic [DW-1:0] core_correction = '0;
   logic          core_veto = 1'b0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic          resp_id;
   logic [DW-1:0] resp_correction;
   logic          resp_veto;
   logic          holdoff, busy;
   logic [7:0]    veto_count;

   always #5 clk_100mhz = ~clk_100mhz;

   fpt_core_scheduler #(
      .CORE_LAT (L),
      .VETO_HOLD(VH),
      .DW       (DW)
   ) dut (
      .clk_100mhz     (clk_100mhz),
      .rst            (rst),
      .s0_valid       (s0_valid),
      .s0_ready       (s0_ready),
      .s0_scrape      (s0_scrape),
      .s0_motor       (s0_motor),
      .s1_valid       (s1_valid),
      .s1_ready       (s1_ready),
      .s1_scrape      (s1_scrape),
      .s1_motor       (s1_motor),
      .core_valid     (core_valid),
      .core_scrape    (core_scrape),
      .core_motor     (core_motor),
      .core_correction(core_correction),
      .core_veto      (core_veto),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_id        (resp_id),
      .resp_correction(resp_correction),
      .resp_veto      (resp_veto),
      .holdoff        (holdoff),
      .busy           (busy),
      .veto_count     (veto_count)
   );

   typedef struct packed {logic [DW-1:0] s; logic [DW-1:0] m;} issue_t;
   typedef struct packed {logic id; logic [DW-1:0] c; logic v;} resp_t;

   issue_t issue_q[$];
   resp_t  resp_q[$];
   issue_t mon_it;
   resp_t  mon_r;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   // Reference model: transaction timeline in absolute cycle numbers.
   bit            outst;
   bit            last_grant;
   int            g_cyc, free_at, vcnt, n_done;
   logic [DW-1:0] cap_corr;
   bit            cap_veto;
   bit            req_v[2];
   logic [DW-1:0] req_s[2];
   logic [DW-1:0] req_m[2];
   int unsigned   p_req, p_ready, p_veto;
   bit            dir_en, dir_veto;
   logic [DW-1:0] dir_corr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
   endtask

   task automatic timeout_fail(input string name);
      n_chk++;
      $display("FAIL %s: cycle budget expired at cycle %0d", name, cyc);
   endtask

   task automatic model_reset();
      outst = 1'b0;
      last_grant = 1'b1;
      free_at = 0;
      vcnt = 0;
      req_v[0] = 1'b0;
      req_v[1] = 1'b0;
      dir_en = 1'b0;
      issue_q.delete();
      resp_q.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_core_valid"}, 32'(core_valid), 0);
      chk({tag, "_s0_ready"}, 32'(s0_ready), 0);
      chk({tag, "_s1_ready"}, 32'(s1_ready), 0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
      chk({tag, "_resp_id"}, 32'(resp_id), 0);
      chk({tag, "_resp_corr"}, 32'(resp_correction), 0);
      chk({tag, "_resp_veto"}, 32'(resp_veto), 0);
      chk({tag, "_holdoff"}, 32'(holdoff), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_veto_count"}, 32'(veto_count), 0);
      chk({tag, "_core_scrape"}, 32'(core_scrape), 0);
      chk({tag, "_core_motor"}, 32'(core_motor), 0);
   endtask

   task automatic apply_reset(input int unsigned ncyc);
      @(posedge clk_100mhz);
      #1;
      rst = 1'b1;
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      resp_ready = 1'b0;
      model_reset();
      #1;
      check_zero("rst_now");
      repeat (ncyc) begin
         @(negedge clk_100mhz);
         check_zero("rst_hold");
      end
      @(posedge clk_100mhz);
      #1;
      rst = 1'b0;
      @(negedge clk_100mhz);
      check_zero("rst_release");
   endtask

   task automatic model_cycle();
      bit idle, hold, exp_cv, exp_rv;
      int grant;
      issue_t it;
      resp_t r;
      idle = !outst && (cyc >= free_at);
      hold = !outst && (cyc < free_at);
      grant = -1;
      if (idle) begin
         if (req_v[0] && req_v[1]) grant = last_grant ? 0 : 1;
         else if (req_v[0]) grant = 0;
         else if (req_v[1]) grant = 1;
      end
      exp_cv = outst && (cyc == g_cyc + 1);
      exp_rv = outst && (cyc >= g_cyc + 2 + int'(L));
      chk("s0_ready", 32'(s0_ready), 32'(grant == 0));
      chk("s1_ready", 32'(s1_ready), 32'(grant == 1));
      chk("busy", 32'(busy), 32'(!idle));
      chk("holdoff", 32'(holdoff), 32'(hold));
      chk("core_valid", 32'(core_valid), 32'(exp_cv));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("veto_count", 32'(veto_count), 32'(vcnt));
      if (outst && (cyc == g_cyc + 1 + int'(L)) && cap_veto && (vcnt < 255)) vcnt++;
      if (exp_rv && resp_ready) begin
         outst = 1'b0;
         free_at = cyc + 1 + (cap_veto ? int'(VH) : 0);
         n_done++;
      end
      if (grant >= 0) begin
         outst = 1'b1;
         g_cyc = cyc;
         last_grant = grant[0];
         if (dir_en) begin
            cap_corr = dir_corr;
            cap_veto = dir_veto;
            dir_en = 1'b0;
         end else begin
            cap_corr = DW'($urandom);
            cap_veto = ($urandom_range(0, 99) < p_veto);
         end
         it.s = req_s[grant];
         it.m = req_m[grant];
         issue_q.push_back(it);
         r.id = grant[0];
         r.c = cap_corr;
         r.v = cap_veto;
         resp_q.push_back(r);
         req_v[grant] = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk_100mhz);
      #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
         if (!req_v[p] && ($urandom_range(0, 99) < p_req)) begin
            req_v[p] = 1'b1;
            req_s[p] = DW'($urandom);
            req_m[p] = DW'($urandom);
         end
      end
      s0_valid = req_v[0];
      s0_scrape = req_s[0];
      s0_motor = req_m[0];
      s1_valid = req_v[1];
      s1_scrape = req_s[1];
      s1_motor = req_m[1];
      resp_ready = ($urandom_range(0, 99) < p_ready);
      // Emulated core: real answer only in the capture cycle, noise otherwise.
      if (outst && (cyc == g_cyc + 1 + int'(L))) begin
         core_correction = cap_corr;
         core_veto = cap_veto;
      end else begin
         core_correction = DW'($urandom);
         core_veto = 1'($urandom_range(0, 1));
      end
      @(negedge clk_100mhz);
      model_cycle();
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      p_req = 0;
      p_ready = 100;
      while ((req_v[0] || req_v[1] || outst || (cyc < free_at)) && (k < 500)) begin
         step();
         k++;
      end
      if (k >= 500) timeout_fail({name, "_drain"});
      chk({name, "_idle"}, 32'(busy), 0);
   endtask

   // Payload monitor, decoupled from the stimulus/model process.
   always @(negedge clk_100mhz) begin
      if (!rst) begin
         if (core_valid) begin
            if (issue_q.size() == 0) begin
               chk("core_valid_unexpected", 32'(core_valid), 0);
            end else begin
               mon_it = issue_q.pop_front();
               chk("core_scrape", 32'(core_scrape), 32'(mon_it.s));
               chk("core_motor", 32'(core_motor), 32'(mon_it.m));
            end
         end
         if (resp_valid) begin
            if (resp_q.size() == 0) begin
               chk("resp_valid_unexpected", 32'(resp_valid), 0);
            end else begin
               mon_r = resp_q[0];
               chk("resp_id", 32'(resp_id), 32'(mon_r.id));
               chk("resp_correction", 32'(resp_correction), 32'(mon_r.c));
               chk("resp_veto", 32'(resp_veto), 32'(mon_r.v));
               if (resp_ready) void'(resp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, target;
      p_req = 0;
      p_ready = 100;
      p_veto = 0;
      n_done = 0;
      g_cyc = 0;
      model_reset();
      apply_reset(3);

      // Continuous contention: first grant to port 0, then strict alternation.
      p_req = 100;
      p_ready = 100;
      p_veto = 0;
      repeat (60) step();
      drain("contention");

      // Directed single request on port 0.
      req_v[0] = 1'b1;
      req_s[0] = 16'h1234;
      req_m[0] = 16'h00FF;
      dir_en = 1'b1;
      dir_corr = 16'hBEEF;
      dir_veto = 1'b0;
      repeat (12) step();
      drain("single");

      // Vetoed transaction on port 1; requests pile up during the hold-off.
      req_v[1] = 1'b1;
      req_s[1] = DW'($urandom);
      req_m[1] = DW'($urandom);
      dir_en = 1'b1;
      dir_corr = DW'($urandom);
      dir_veto = 1'b1;
      step();
      p_req = 100;
      repeat (30) step();
      drain("veto");

      // Response backpressure.
      p_req = 100;
      p_ready = 0;
      repeat (20) step();
      p_ready = 100;
      repeat (20) step();
      drain("backpressure");

      // Random traffic.
      p_req = 40;
      p_ready = 60;
      p_veto = 20;
      repeat (1500) step();
      drain("random");

      // Veto counter saturation.
      p_req = 100;
      p_ready = 100;
      p_veto = 100;
      target = n_done + 260;
      k = 0;
      while ((n_done < target) && (k < 8000)) begin
         step();
         k++;
      end
      if (k >= 8000) timeout_fail("saturation");
      chk("veto_count_saturated", 32'(veto_count), 32'd255);
      p_veto = 0;
      drain("saturation");

      // Reset while the core latency is still counting down.
      req_v[0] = 1'b1;
      req_s[0] = DW'($urandom);
      req_m[0] = DW'($urandom);
      k = 0;
      while (!(outst && (cyc >= g_cyc + 1) && (cyc <= g_cyc + int'(L) - 1)) && (k < 50)) begin
         step();
         k++;
      end
      if (k >= 50) timeout_fail("reach_wait");
      apply_reset(2);
      p_req = 0;
      repeat (20) step();

      // Arbitration restarts from port 0 after reset.
      p_req = 100;
      repeat (20) step();
      drain("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
